// File: rtl/tcp_pkg.sv
// Shared widths, state encoding and pointer helpers for the RX payload pointer logic.
package tcp_pkg;

    localparam int FLOWID_W          = 8;
    localparam int RX_PAYLOAD_PTR_W  = 12;
    localparam int RX_PTR_W          = RX_PAYLOAD_PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        APP_RESP,
        WR_REQ,
        CHK_REQ,
        CHK_RESP
    } rx_app_ptr_state_e;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        logic [RX_PTR_W-1:0] head;
        logic [RX_PTR_W-1:0] commit;
        logic [RX_PTR_W-1:0] avail;
    } rx_app_query_resp_struct;

    // Forward distance from a to b; the wrap bit makes the truncated difference exact.
    function automatic logic [RX_PTR_W-1:0] rx_ptr_dist(input logic [RX_PTR_W-1:0] a,
                                                       input logic [RX_PTR_W-1:0] b);
        return b - a;
    endfunction

endpackage

// File: rtl/rx_app_head_ptr_ctrl.sv
// App-side RX head/commit pointer controller: serves occupancy queries and head advances.
// Optional build macro RX_HEAD_UPDATE_CHECK_EN rejects head advances beyond the commit pointer.
module rx_app_head_ptr_ctrl
    import tcp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                app_rx_query_req_val,
    input  logic [FLOWID_W-1:0] app_rx_query_req_flowid,
    output logic                app_rx_query_req_rdy,

    output logic                app_rx_query_resp_val,
    output logic [FLOWID_W-1:0] app_rx_query_resp_flowid,
    output logic [RX_PTR_W-1:0] app_rx_query_resp_head,
    output logic [RX_PTR_W-1:0] app_rx_query_resp_commit,
    output logic [RX_PTR_W-1:0] app_rx_query_resp_avail,
    input  logic                app_rx_query_resp_rdy,

    input  logic                app_rx_update_req_val,
    input  logic [FLOWID_W-1:0] app_rx_update_req_flowid,
    input  logic [RX_PTR_W-1:0] app_rx_update_req_head,
    output logic                app_rx_update_req_rdy,

    output logic                head_ptr_rd_req_val,
    output logic [FLOWID_W-1:0] head_ptr_rd_req_addr,
    input  logic                head_ptr_rd_req_rdy,

    input  logic                head_ptr_rd_resp_val,
    input  logic [RX_PTR_W-1:0] head_ptr_rd_resp_data,
    output logic                head_ptr_rd_resp_rdy,

    output logic                commit_ptr_rd_req_val,
    output logic [FLOWID_W-1:0] commit_ptr_rd_req_addr,
    input  logic                commit_ptr_rd_req_rdy,

    input  logic                commit_ptr_rd_resp_val,
    input  logic [RX_PTR_W-1:0] commit_ptr_rd_resp_data,
    output logic                commit_ptr_rd_resp_rdy,

    output logic                head_ptr_wr_req_val,
    output logic [FLOWID_W-1:0] head_ptr_wr_req_addr,
    output logic [RX_PTR_W-1:0] head_ptr_wr_req_data,
    input  logic                head_ptr_wr_req_rdy,

    output logic                head_update_err
);

    rx_app_ptr_state_e       state;
    logic                    head_done;
    logic                    commit_done;

    logic [FLOWID_W-1:0]     flowid_q;
    logic [RX_PTR_W-1:0]     upd_head_q;
    logic [RX_PTR_W-1:0]     rd_head_q;
    logic [RX_PTR_W-1:0]     rd_commit_q;
    rx_app_query_resp_struct resp;

    logic query_hs;
    logic update_hs;
    logic head_req_hs;
    logic commit_req_hs;
    logic head_resp_hs;
    logic commit_resp_hs;
    logic both_req_done;
    logic both_resp_done;

    // Updates take priority over queries arriving in the same cycle.
    assign app_rx_update_req_rdy = (state == IDLE);
    assign app_rx_query_req_rdy  = (state == IDLE) && !app_rx_update_req_val;

    assign query_hs       = app_rx_query_req_val && app_rx_query_req_rdy;
    assign update_hs      = app_rx_update_req_val && app_rx_update_req_rdy;
    assign head_req_hs    = head_ptr_rd_req_val && head_ptr_rd_req_rdy;
    assign commit_req_hs  = commit_ptr_rd_req_val && commit_ptr_rd_req_rdy;
    assign head_resp_hs   = head_ptr_rd_resp_val && head_ptr_rd_resp_rdy;
    assign commit_resp_hs = commit_ptr_rd_resp_val && commit_ptr_rd_resp_rdy;

    assign both_req_done  = (head_done || head_req_hs) && (commit_done || commit_req_hs);
    assign both_resp_done = (head_done || head_resp_hs) && (commit_done || commit_resp_hs);

`ifdef RX_HEAD_UPDATE_CHECK_EN
    logic                err_q;
    logic [RX_PTR_W-1:0] cur_head;
    logic [RX_PTR_W-1:0] cur_commit;
    logic                update_legal;

    // A pointer may arrive in the same cycle the decision is made, so bypass the latch.
    assign cur_head     = head_done ? rd_head_q : head_ptr_rd_resp_data;
    assign cur_commit   = commit_done ? rd_commit_q : commit_ptr_rd_resp_data;
    assign update_legal = rx_ptr_dist(cur_head, upd_head_q) <= rx_ptr_dist(cur_head, cur_commit);
    assign head_update_err = err_q;
`else
    assign head_update_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            head_done              <= 1'b0;
            commit_done            <= 1'b0;
            head_ptr_rd_req_val    <= 1'b0;
            commit_ptr_rd_req_val  <= 1'b0;
            head_ptr_rd_resp_rdy   <= 1'b0;
            commit_ptr_rd_resp_rdy <= 1'b0;
            head_ptr_wr_req_val    <= 1'b0;
            app_rx_query_resp_val  <= 1'b0;
`ifdef RX_HEAD_UPDATE_CHECK_EN
            err_q                  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (update_hs) begin
`ifdef RX_HEAD_UPDATE_CHECK_EN
                        state                 <= CHK_REQ;
                        head_ptr_rd_req_val   <= 1'b1;
                        commit_ptr_rd_req_val <= 1'b1;
`else
                        state                 <= WR_REQ;
                        head_ptr_wr_req_val   <= 1'b1;
`endif
                    end else if (query_hs) begin
                        state                 <= RD_REQ;
                        head_ptr_rd_req_val   <= 1'b1;
                        commit_ptr_rd_req_val <= 1'b1;
                    end
                end
                RD_REQ, CHK_REQ: begin
                    if (head_req_hs) begin
                        head_ptr_rd_req_val <= 1'b0;
                        head_done           <= 1'b1;
                    end
                    if (commit_req_hs) begin
                        commit_ptr_rd_req_val <= 1'b0;
                        commit_done           <= 1'b1;
                    end
                    if (both_req_done) begin
                        state                  <= (state == RD_REQ) ? RD_RESP : CHK_RESP;
                        head_done              <= 1'b0;
                        commit_done            <= 1'b0;
                        head_ptr_rd_resp_rdy   <= 1'b1;
                        commit_ptr_rd_resp_rdy <= 1'b1;
                    end
                end
                RD_RESP, CHK_RESP: begin
                    if (head_resp_hs) begin
                        head_ptr_rd_resp_rdy <= 1'b0;
                        head_done            <= 1'b1;
                    end
                    if (commit_resp_hs) begin
                        commit_ptr_rd_resp_rdy <= 1'b0;
                        commit_done            <= 1'b1;
                    end
                    if (both_resp_done) begin
                        head_done              <= 1'b0;
                        commit_done            <= 1'b0;
                        head_ptr_rd_resp_rdy   <= 1'b0;
                        commit_ptr_rd_resp_rdy <= 1'b0;
                        if (state == RD_RESP) begin
                            state                 <= APP_RESP;
                            app_rx_query_resp_val <= 1'b1;
                        end else begin
`ifdef RX_HEAD_UPDATE_CHECK_EN
                            if (update_legal) begin
                                state               <= WR_REQ;
                                head_ptr_wr_req_val <= 1'b1;
                            end else begin
                                state <= IDLE;
                                err_q <= 1'b1;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                APP_RESP: begin
                    if (app_rx_query_resp_rdy) begin
                        app_rx_query_resp_val <= 1'b0;
                        state                 <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (head_ptr_wr_req_rdy) begin
                        head_ptr_wr_req_val <= 1'b0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath latches, kept apart from the control sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            flowid_q    <= '0;
            upd_head_q  <= '0;
            rd_head_q   <= '0;
            rd_commit_q <= '0;
        end else begin
            if (update_hs) begin
                flowid_q   <= app_rx_update_req_flowid;
                upd_head_q <= app_rx_update_req_head;
            end else if (query_hs) begin
                flowid_q <= app_rx_query_req_flowid;
            end
            if (head_resp_hs) begin
                rd_head_q <= head_ptr_rd_resp_data;
            end
            if (commit_resp_hs) begin
                rd_commit_q <= commit_ptr_rd_resp_data;
            end
        end
    end

    assign resp.flowid = flowid_q;
    assign resp.head   = rd_head_q;
    assign resp.commit = rd_commit_q;
    assign resp.avail  = rx_ptr_dist(rd_head_q, rd_commit_q);

    assign app_rx_query_resp_flowid = resp.flowid;
    assign app_rx_query_resp_head   = resp.head;
    assign app_rx_query_resp_commit = resp.commit;
    assign app_rx_query_resp_avail  = resp.avail;

    assign head_ptr_rd_req_addr   = flowid_q;
    assign commit_ptr_rd_req_addr = flowid_q;
    assign head_ptr_wr_req_addr   = flowid_q;
    assign head_ptr_wr_req_data   = upd_head_q;

endmodule
